// File: rtl/stride_demux_1x2_if.sv
// Stream-side bundle for stride_demux_1x2: serial sample input, paired lane output.
// The master side sources samples and sinks pairs. The slave side is the demux.
interface stride_demux_1x2_if #(
   parameter int DATA_W = 32,
   parameter int STRIDE = 8
);
   localparam int IDX_W = $clog2(STRIDE);

   logic              in_valid;
   logic              in_sof;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic [DATA_W-1:0] out_a;
   logic [DATA_W-1:0] out_b;
   logic [IDX_W-1:0]  out_idx;
   logic              out_sof;
   logic              sof_err;

   modport master (
      output in_valid, in_sof, in_data,
      input  out_valid, out_a, out_b, out_idx, out_sof, sof_err
   );

   modport slave (
      input  in_valid, in_sof, in_data,
      output out_valid, out_a, out_b, out_idx, out_sof, sof_err
   );
endinterface

// File: rtl/stride_demux_1x2.sv
// Splits a serial stream of 2*STRIDE-sample frames into (x[k], x[k+STRIDE]) lane pairs.
// The first half of each frame is buffered. Each second-half sample releases one pair.
module stride_demux_1x2 #(
   parameter int DATA_W = 32,
   parameter int STRIDE = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   stride_demux_1x2_if.slave     bus
);
   localparam int IDX_W = $clog2(STRIDE);
   localparam int CNT_W = IDX_W + 1;

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  e;
   logic [IDX_W-1:0]  k;
   logic              second;
   logic [DATA_W-1:0] buffer [STRIDE];

   // A qualified in_sof forces index 0 and realigns the frame.
   always_comb begin
      e = cnt;
      if (bus.in_valid && bus.in_sof) e = '0;
   end

   assign k      = e[IDX_W-1:0];
   assign second = e[IDX_W];

   // No reset on the buffer. Each slot is written before it is read within a frame.
   always_ff @(posedge clk) begin
      if (bus.in_valid && !second) buffer[k] <= bus.in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         bus.out_valid <= 1'b0;
         bus.out_a     <= '0;
         bus.out_b     <= '0;
         bus.out_idx   <= '0;
         bus.out_sof   <= 1'b0;
         bus.sof_err   <= 1'b0;
      end else begin
         bus.out_valid <= 1'b0;
         bus.out_sof   <= 1'b0;
         bus.sof_err   <= bus.in_valid && bus.in_sof && (cnt != '0);
         if (bus.in_valid) begin
            cnt <= e + 1'b1;
            if (second) begin
               bus.out_valid <= 1'b1;
               bus.out_a     <= buffer[k];
               bus.out_b     <= bus.in_data;
               bus.out_idx   <= k;
               bus.out_sof   <= (k == '0);
            end
         end
      end
   end
endmodule

// File: doc/stride_demux_1x2.md
# stride_demux_1x2

Sequential 1-to-2 demultiplexer for the parallel FFT datapath. It takes a single serial stream of complex samples in frames of 2·STRIDE. It emits lane pairs (x[k], x[k+STRIDE]) on two parallel outputs, which is the input ordering a 2-parallel radix-2 butterfly stage needs. It is the distributing end of the lane-select muxes in the data shuffler: it splits one stream into two lanes, where the muxes merge lanes into one.

## Interface
- DATA_W, 32, sample width (16-bit real/16-bit imaginary packed, treated as opaque)
- STRIDE, 8, pair distance = half frame length; power of two, minimum 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data carries a sample this cycle
- in_sof  input  1  start-of-frame; qualified by in_valid; marks sample index 0
- in_data  input  DATA_W  serial sample
- out_valid  output  1  out_a/out_b carry a pair this cycle
- out_a  output  DATA_W  x[k]
- out_b  output  DATA_W  x[k+STRIDE]
- out_idx  output  log2(STRIDE)  pair index k
- out_sof  output  1  high with out_valid when k==0
- sof_err  output  1  one-cycle pulse: in_sof arrived while the frame counter was not 0

## Operation
- Frame counter cnt, width log2(2·STRIDE), advances by 1 on every in_valid and wraps at 2·STRIDE-1 → 0. It holds when in_valid is low, so arbitrary input gaps are allowed.
- Effective index e = 0 if (in_valid & in_sof), else cnt. After any valid sample, cnt ← e+1 (mod 2·STRIDE).
- First half, e < STRIDE: write in_data to buffer[e]. No output is produced.
- Second half, e ≥ STRIDE, k = e-STRIDE: register out_a ← buffer[k], out_b ← in_data, out_idx ← k, out_sof ← (k==0), out_valid ← 1.
- Buffer: STRIDE×DATA_W register array or inferred RAM with asynchronous read. It is not reset; contents before the first write are don't-care.
- in_sof with cnt != 0: a realignment. The partial frame is discarded and sof_err pulses. Pairs already emitted stay emitted. The sample is stored as index 0.
- in_sof without in_valid is ignored.
- in_sof is not required. With no in_sof, framing follows the counter from reset.
- No backpressure. The consumer must accept every out_valid cycle.

## Timing
- Reset (rst_n low, asynchronous): cnt=0, out_valid=0, out_a=0, out_b=0, out_idx=0, out_sof=0, sof_err=0.
- Latency: 1 clk from the in_valid edge of sample k+STRIDE to out_valid with pair k.
- out_valid is high for exactly one cycle per second-half input sample. Throughput is STRIDE pairs per 2·STRIDE input samples.
- sof_err is registered and rises in the cycle after the offending in_sof sample.
- Wrap: the sample after index 2·STRIDE-1 is index 0 of the next frame. Back-to-back frames need no idle cycles.
- Reset mid-frame: the partial frame is lost. The first valid sample after rst_n deasserts is index 0. No pair from the lost frame is emitted.
- Buffer read of address k and write of address e never coincide, because the two halves are exclusive. No read-during-write hazard exists.

## Test plan
STRIDE=4 throughout.
- Continuous frame, in_sof on the first sample, in_data = 0..7 every cycle → four out_valid pulses with (a,b,idx) = (0,4,0), (1,5,1), (2,6,2), (3,7,3). out_sof only on the first. Pair 0 appears 1 clk after sample 4.
- Same frame with in_valid low on every other cycle → identical pair values. Each out_valid occurs 1 clk after its second-half sample. Counter holds across gaps.
- Two back-to-back frames, 0..7 then 100..107 with no idle cycles → pairs (0,4)…(3,7) then (100,104)…(103,107). out_sof on idx 0 of each frame. sof_err stays 0.
- Samples 0..5, then in_sof on sample 50 followed by 51..57 → pairs (0,4), (1,5) emitted. sof_err pulses once. Then pairs (50,54), (51,55), (52,56), (53,57).
- Async rst_n asserted mid-second-half, between clock edges → all outputs are 0 immediately. After release, samples 10..17 without in_sof give pairs (10,14)…(13,17).
- in_sof high with in_valid low while cnt=3 → no realignment and no sof_err. The next valid sample is index 3.
